// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the AXI SRAM responder.
// Response codes, FSM states and the LFSR seed.
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_DLY,
    RD_RESP,
    WR_DATA,
    WR_DLY,
    WR_RESP
  } sram_fsm_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/ysyx_24080006_axi.sv
// AXI4 bundle between the core master ports and memory responders.
// Single-beat subset: no cache/prot/qos/user signals.
interface ysyx_24080006_axi;

  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport slave (
    input  arvalid, arid, araddr, arlen,
    input  arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awid, awaddr, awlen,
    input  awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );

  modport master (
    output arvalid, arid, araddr, arlen,
    output arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awid, awaddr, awlen,
    output awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

endinterface

// File: rtl/ysyx_24080006_lfsr.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Free-running; async reset loads SEED.
module ysyx_24080006_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);

  logic fb;

  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= {q[14:0], fb};
  end

endmodule

// File: rtl/ysyx_24080006_axi_sram_slave.sv
// Single-outstanding, single-beat AXI4 SRAM responder.
// YSYX_24080006_AXI_SRAM_RAND_DELAY_EN: LFSR-driven response delay.
module ysyx_24080006_axi_sram_slave
  import ysyx_24080006_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 4096,
  parameter int          LAT   = 1
) (
  input logic             clock,
  input logic             reset,
  ysyx_24080006_axi.slave axi_s
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) * 32'd4;

  sram_fsm_e   state_q, state_d;
  logic [3:0]  cnt_q, dly_load;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic [31:0] rdata_q;
  axi_resp_e   rresp_q, bresp_q, resp;
  logic [3:0]  rid_q, bid_q;

  logic [31:0] mem [DEPTH];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        in_range;

  logic arready, awready, wready;
  logic rvalid, bvalid;
  logic ar_hs, aw_hs, w_hs;

`ifdef YSYX_24080006_AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  ysyx_24080006_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign dly_load = lfsr_q[3:0];

  logic unused_lfsr;
  assign unused_lfsr = &{1'b0, lfsr_q[15:4]};
`else
  assign dly_load = 4'(LAT);
`endif

  assign off      = addr_q - BASE;
  assign idx      = off[AW+1:2];
  assign in_range = (addr_q >= BASE) && (off < SPAN);

  // decode error dominates protocol error
  always_comb begin
    resp = OKAY;
    if (!in_range)
      resp = DECERR;
    else if (len_q != 8'd0 || burst_q == 2'b11)
      resp = SLVERR;
  end

  assign ar_hs = axi_s.arvalid && arready;
  assign aw_hs = axi_s.awvalid && awready;
  assign w_hs  = axi_s.wvalid && wready;

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        arready = 1'b1;
        awready = !axi_s.arvalid;
        if (axi_s.arvalid)
          state_d = RD_DLY;
        else if (axi_s.awvalid)
          state_d = WR_DATA;
      end
      RD_DLY: begin
        if (cnt_q == 4'd0) state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (axi_s.rready) state_d = IDLE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (axi_s.wvalid && axi_s.wlast)
          state_d = WR_DLY;
      end
      WR_DLY: begin
        if (cnt_q == 4'd0) state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (axi_s.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      burst_q <= 2'b00;
      rdata_q <= 32'd0;
      rresp_q <= OKAY;
      rid_q   <= 4'd0;
      bresp_q <= OKAY;
      bid_q   <= 4'd0;
    end else begin
      if (ar_hs) begin
        id_q    <= axi_s.arid;
        addr_q  <= axi_s.araddr;
        len_q   <= axi_s.arlen;
        burst_q <= axi_s.arburst;
        cnt_q   <= dly_load;
      end else if (aw_hs) begin
        id_q    <= axi_s.awid;
        addr_q  <= axi_s.awaddr;
        len_q   <= axi_s.awlen;
        burst_q <= axi_s.awburst;
      end
      if (w_hs && axi_s.wlast)
        cnt_q <= dly_load;
      if ((state_q == RD_DLY || state_q == WR_DLY)
          && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      // response fields freeze on entry to the RESP state
      if (state_q == RD_DLY && cnt_q == 4'd0) begin
        rdata_q <= (resp == OKAY) ? mem[idx] : 32'd0;
        rresp_q <= resp;
        rid_q   <= id_q;
      end
      if (state_q == WR_DLY && cnt_q == 4'd0) begin
        bresp_q <= resp;
        bid_q   <= id_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs && resp == OKAY) begin
      for (int i = 0; i < 4; i++) begin
        if (axi_s.wstrb[i])
          mem[idx][8*i +: 8] <= axi_s.wdata[8*i +: 8];
      end
    end
  end

  assign axi_s.arready = arready;
  assign axi_s.awready = awready;
  assign axi_s.wready  = wready;
  assign axi_s.rvalid  = rvalid;
  assign axi_s.rdata   = rdata_q;
  assign axi_s.rresp   = rresp_q;
  assign axi_s.rid     = rid_q;
  assign axi_s.rlast   = 1'b1;
  assign axi_s.bvalid  = bvalid;
  assign axi_s.bresp   = bresp_q;
  assign axi_s.bid     = bid_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, axi_s.arsize, axi_s.awsize,
                       off[31:AW+2], off[1:0]};

endmodule

// File: tb/tb_ysyx_24080006_axi_sram_slave.sv
// Bench for ysyx_24080006_axi_sram_slave (default LAT=1).
// Table of single transactions plus hand-written corner sequences.
module tb_ysyx_24080006_axi_sram_slave;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  ysyx_24080006_axi bus ();

  ysyx_24080006_axi_sram_slave dut (
    .clock (clock),
    .reset (reset),
    .axi_s (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  task automatic aw_phase(input logic [31:0] a,
                          input logic [7:0] len,
                          input logic [1:0] burst,
                          input logic [3:0] id);
    int n;
    @(negedge clock);
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.awlen   = len;
    bus.awburst = burst;
    bus.awid    = id;
    bus.awsize  = 3'd2;
    #1;
    n = 0;
    while (!bus.awready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) timeout("awready");
    @(negedge clock);
    bus.awvalid = 1'b0;
  endtask

  task automatic wb_phase(input logic [31:0] d,
                          input logic [3:0] strb,
                          input logic [7:0] len,
                          output logic [1:0] resp,
                          output logic [3:0] bid,
                          output int lat);
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = d;
      bus.wstrb  = strb;
      bus.wlast  = (b == int'(len));
      #1;
      n = 0;
      while (!bus.wready && n < 20) begin
        @(negedge clock); #1; n++;
      end
      if (n >= 20) timeout("wready");
      @(negedge clock);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    bus.bready = 1'b1;
    #1;
    lat = 0;
    while (!bus.bvalid && lat < 40) begin
      @(negedge clock); #1; lat++;
    end
    if (lat >= 40) timeout("bvalid");
    resp = bus.bresp;
    bid  = bus.bid;
    @(negedge clock);
    bus.bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [7:0] len,
                    input logic [1:0] burst,
                    input logic [3:0] id,
                    output logic [31:0] data,
                    output logic [1:0] resp,
                    output logic [3:0] rid,
                    output logic last,
                    output int lat);
    int n;
    @(negedge clock);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arid    = id;
    bus.arsize  = 3'd2;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) timeout("arready");
    @(negedge clock);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    #1;
    lat = 0;
    while (!bus.rvalid && lat < 40) begin
      @(negedge clock); #1; lat++;
    end
    if (lat >= 40) timeout("rvalid");
    data = bus.rdata;
    resp = bus.rresp;
    rid  = bus.rid;
    last = bus.rlast;
    @(negedge clock);
    bus.rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
    int          lat;
    int          n;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 8'd0, 2'b01, 4'h3, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h8000_0012, 32'h0, 4'h0, 8'd0, 2'b01, 4'h5, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 8'd0, 2'b01, 4'h1, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 8'd0, 2'b01, 4'h4, 2'b00, 32'hDE22_BE44};
    vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 8'd0, 2'b01, 4'h2, 2'b11, 32'h0};
    vecs[5]  = '{1'b1, 32'h8000_0010, 32'h5566_7788, 4'hF, 8'd1, 2'b01, 4'h6, 2'b10, 32'h0};
    vecs[6]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 8'd0, 2'b01, 4'h7, 2'b00, 32'hDE22_BE44};
    vecs[7]  = '{1'b1, 32'h8000_3FFC, 32'hAABB_CCDD, 4'hF, 8'd0, 2'b01, 4'h8, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h8000_3FFF, 32'h0, 4'h0, 8'd0, 2'b01, 4'h9, 2'b00, 32'hAABB_CCDD};
    vecs[9]  = '{1'b0, 32'h8000_4000, 32'h0, 4'h0, 8'd0, 2'b01, 4'hA, 2'b11, 32'h0};
    vecs[10] = '{1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 8'd0, 2'b01, 4'hB, 2'b00, 32'h0};
    vecs[11] = '{1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, 8'd0, 2'b11, 4'hC, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 8'd0, 2'b01, 4'hD, 2'b00, 32'hCAFE_F00D};
    vecs[13] = '{1'b1, 32'h8000_0020, 32'h9900_0000, 4'h8, 8'd0, 2'b01, 4'hE, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 8'd0, 2'b01, 4'hF, 2'b00, 32'h99FE_F00D};
    vecs[15] = '{1'b1, 32'h9000_0000, 32'h0BAD_0BAD, 4'hF, 8'd0, 2'b01, 4'h0, 2'b11, 32'h0};
    vecs[16] = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 8'd3, 2'b01, 4'h1, 2'b10, 32'h0};
    vecs[17] = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 8'd0, 2'b11, 4'h2, 2'b10, 32'h0};

    reset       = 1'b1;
    bus.arvalid = 1'b0;
    bus.arid    = 4'h0;
    bus.araddr  = 32'h0;
    bus.arlen   = 8'd0;
    bus.arsize  = 3'd2;
    bus.arburst = 2'b01;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.awid    = 4'h0;
    bus.awaddr  = 32'h0;
    bus.awlen   = 8'd0;
    bus.awsize  = 3'd2;
    bus.awburst = 2'b01;
    bus.wvalid  = 1'b0;
    bus.wdata   = 32'h0;
    bus.wstrb   = 4'h0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check("rst arready", 32'(bus.arready), 32'd1);
    check("rst awready", 32'(bus.awready), 32'd1);
    check("rst wready", 32'(bus.wready), 32'd0);
    check("rst valids", {30'd0, bus.rvalid, bus.bvalid}, 32'd0);
    check("rst rdata", bus.rdata, 32'd0);
    check("rst rfields", {25'd0, bus.rresp, bus.rid, bus.rlast}, 32'd1);
    check("rst bfields", {26'd0, bus.bresp, bus.bid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        aw_phase(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].id);
        wb_phase(vecs[i].data, vecs[i].strb, vecs[i].len, resp, id, lat);
        check($sformatf("v%0d bresp", i), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("v%0d bid", i), 32'(id), 32'(vecs[i].id));
        check($sformatf("v%0d blat", i), 32'(lat), 32'd2);
      end else begin
        rd(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].id,
           rdata, resp, id, last, lat);
        check($sformatf("v%0d rresp", i), 32'(resp), 32'(vecs[i].resp));
        check($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
        check($sformatf("v%0d rid", i), 32'(id), 32'(vecs[i].id));
        check($sformatf("v%0d rlast", i), 32'(last), 32'd1);
        check($sformatf("v%0d rlat", i), 32'(lat), 32'd2);
      end
    end

    // W ahead of AW is held off
    @(negedge clock);
    bus.wvalid = 1'b1;
    bus.wlast  = 1'b1;
    #1;
    check("w before aw wready", 32'(bus.wready), 32'd0);
    @(negedge clock);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;

    // simultaneous AR and AW: read first
    @(negedge clock);
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h8000_0010;
    bus.arlen   = 8'd0;
    bus.arburst = 2'b01;
    bus.arid    = 4'h9;
    bus.awvalid = 1'b1;
    bus.awaddr  = 32'h8000_0030;
    bus.awlen   = 8'd0;
    bus.awburst = 2'b01;
    bus.awid    = 4'hA;
    #1;
    check("sim arready", 32'(bus.arready), 32'd1);
    check("sim awready", 32'(bus.awready), 32'd0);
    @(negedge clock);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    #1;
    check("sim awready busy", 32'(bus.awready), 32'd0);
    n = 0;
    while (!bus.rvalid && n < 40) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 40) timeout("sim rvalid");
    check("sim rdata", bus.rdata, 32'hDE22_BE44);
    check("sim rid", 32'(bus.rid), 32'h9);
    @(negedge clock);
    bus.rready = 1'b0;
    #1;
    check("sim awready after r", 32'(bus.awready), 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
    wb_phase(32'h0BAD_CAFE, 4'hF, 8'd0, resp, id, lat);
    check("sim bresp", 32'(resp), 32'd0);
    check("sim bid", 32'(id), 32'hA);
    rd(32'h8000_0030, 8'd0, 2'b01, 4'h3, rdata, resp, id, last, lat);
    check("sim readback", rdata, 32'h0BAD_CAFE);

    // rready stall: response must hold
    @(negedge clock);
    bus.arvalid = 1'b1;
    bus.araddr  = 32'h8000_0020;
    bus.arid    = 4'h6;
    #1;
    n = 0;
    while (!bus.arready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) timeout("stall arready");
    @(negedge clock);
    bus.arvalid = 1'b0;
    #1;
    n = 0;
    while (!bus.rvalid && n < 40) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 40) timeout("stall rvalid");
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1;
      check($sformatf("stall%0d rvalid", c), 32'(bus.rvalid), 32'd1);
      check($sformatf("stall%0d rdata", c), bus.rdata, 32'h99FE_F00D);
      check($sformatf("stall%0d rid", c), 32'(bus.rid), 32'h6);
    end
    bus.rready = 1'b1;
    @(negedge clock);
    bus.rready = 1'b0;
    #1;
    check("stall rvalid drop", 32'(bus.rvalid), 32'd0);

    // reset during WR_DLY: W already taken, so the write lands
    aw_phase(32'h8000_0040, 8'd0, 2'b01, 4'h5);
    bus.wvalid = 1'b1;
    bus.wdata  = 32'h7777_1234;
    bus.wstrb  = 4'hF;
    bus.wlast  = 1'b1;
    #1;
    n = 0;
    while (!bus.wready && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 20) timeout("rst wready");
    @(negedge clock);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    reset = 1'b1;
    #1;
    check("rstdly bvalid", 32'(bus.bvalid), 32'd0);
    check("rstdly arready", 32'(bus.arready), 32'd1);
    check("rstdly awready", 32'(bus.awready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rstdly bvalid later", 32'(bus.bvalid), 32'd0);
    rd(32'h8000_0040, 8'd0, 2'b01, 4'h1, rdata, resp, id, last, lat);
    check("rstdly readback", rdata, 32'h7777_1234);
    check("rstdly rresp", 32'(resp), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
